// File: rtl/shift_reg_univ_if.sv
// -----------------------------------------------------------------------------
// shift_reg_univ_if
//   Bundles the control, data and status signals of shift_reg_univ.
//   Signal names carry the direction as seen from the shift register.
//
//   i_mode      2      manual op: 00 hold, 01 shift right, 10 shift left, 11 load
//   i_data_in   WIDTH  parallel load word
//   i_sin_r     1      fill bit entering the MSB on a right shift
//   i_sin_l     1      fill bit entering the LSB on a left shift
//   i_start     1      burst request (only honoured in IDLE)
//   i_dir       1      burst direction: 0 right (LSB first), 1 left (MSB first)
//   o_data_out  WIDTH  register contents
//   o_sout_r    1      data_out[0]
//   o_sout_l    1      data_out[WIDTH-1]
//   o_busy      1      burst shifting in progress
//   o_done      1      one-cycle burst completion pulse
//   o_bit_cnt   CNT_W  burst shifts completed
//
//   master: the block driving the shift register; slave: the shift register.
// -----------------------------------------------------------------------------
interface shift_reg_univ_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       i_mode;
    logic [WIDTH-1:0] i_data_in;
    logic             i_sin_r;
    logic             i_sin_l;
    logic             i_start;
    logic             i_dir;
    logic [WIDTH-1:0] o_data_out;
    logic             o_sout_r;
    logic             o_sout_l;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_bit_cnt;

    modport master (
        output i_mode, i_data_in, i_sin_r, i_sin_l, i_start, i_dir,
        input  o_data_out, o_sout_r, o_sout_l, o_busy, o_done, o_bit_cnt
    );

    modport slave (
        input  i_mode, i_data_in, i_sin_r, i_sin_l, i_start, i_dir,
        output o_data_out, o_sout_r, o_sout_l, o_busy, o_done, o_bit_cnt
    );
endinterface

// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ
//   Universal shift register of WIDTH bits (legal range 2..32) with hold,
//   shift right, shift left and parallel load, plus a burst serialiser that
//   loads a word and shifts it out over exactly WIDTH cycles.
//
//   i_clk    clock, rising edge active
//   i_rst_n  asynchronous active-low reset
//   bus      shift_reg_univ_if slave port (mode, data, serial in/out, status)
// -----------------------------------------------------------------------------
module shift_reg_univ #(
    parameter int WIDTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    shift_reg_univ_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;

    // Burst and manual shifts share the same fill rule.
    assign w_shr = {bus.i_sin_r, r_data[WIDTH-1:1]};
    assign w_shl = {r_data[WIDTH-2:0], bus.i_sin_l};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        case (r_state)
            ST_IDLE: begin
                // start outranks the manual mode
                if (bus.i_start) begin
                    w_data_nxt  = bus.i_data_in;
                    w_dir_nxt   = bus.i_dir;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    case (bus.i_mode)
                        2'b01:   w_data_nxt = w_shr;
                        2'b10:   w_data_nxt = w_shl;
                        2'b11:   w_data_nxt = bus.i_data_in;
                        default: w_data_nxt = r_data;
                    endcase
                end
            end
            ST_SHIFT: begin
                w_data_nxt = r_dir ? w_shl : w_shr;
                w_cnt_nxt  = r_cnt + CNT_W'(1);
                // r_cnt==WIDTH-1 means this edge performs the final shift
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.o_data_out = r_data;
    assign bus.o_sout_r   = r_data[0];
    assign bus.o_sout_l   = r_data[WIDTH-1];
    assign bus.o_busy     = (r_state == ST_SHIFT);
    assign bus.o_done     = (r_state == ST_DONE);
    assign bus.o_bit_cnt  = r_cnt;
endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_reg_univ_if #(.WIDTH(W)) bus ();

    shift_reg_univ #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         busy;
        logic         done;
        int           cnt;
        logic         ser_vld;
        logic         ser_dir;
        logic         ser_bit;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int busy_cycles = 0;
    int done_cycles = 0;
    logic [W-1:0] cap_r = '0;

    // Reference model: register value as an integer, burst position
    // -1 = idle, 0..W-1 = shifts done so far while bursting, W = done.
    logic [W-1:0] m_reg  = '0;
    logic [W-1:0] m_word = '0;
    logic         m_dir  = 1'b0;
    int           m_pos  = -1;
    int           m_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] shift_right(input logic [W-1:0] v, input logic fill);
        return (v >> 1) | (W'(fill) << (W - 1));
    endfunction

    function automatic logic [W-1:0] shift_left(input logic [W-1:0] v, input logic fill);
        return W'((v << 1) | W'(fill));
    endfunction

    task automatic model_step();
        exp_t e;
        if (m_pos < 0) begin
            if (bus.i_start) begin
                m_reg  = bus.i_data_in;
                m_word = bus.i_data_in;
                m_dir  = bus.i_dir;
                m_cnt  = 0;
                m_pos  = 0;
            end else begin
                case (bus.i_mode)
                    2'b01: m_reg = shift_right(m_reg, bus.i_sin_r);
                    2'b10: m_reg = shift_left(m_reg, bus.i_sin_l);
                    2'b11: m_reg = bus.i_data_in;
                    default: ;
                endcase
            end
        end else if (m_pos < W) begin
            m_reg = m_dir ? shift_left(m_reg, bus.i_sin_l) : shift_right(m_reg, bus.i_sin_r);
            m_pos++;
            m_cnt = m_pos;
        end else begin
            m_pos = -1;
        end
        e.data    = m_reg;
        e.busy    = (m_pos >= 0) && (m_pos < W);
        e.done    = (m_pos == W);
        e.cnt     = m_cnt;
        e.ser_vld = e.busy;
        e.ser_dir = m_dir;
        e.ser_bit = 1'b0;
        if (e.busy) e.ser_bit = m_dir ? m_word[W-1-m_pos] : m_word[m_pos];
        q.push_back(e);
    endtask

    task automatic drive(input logic st, input logic [1:0] md, input logic [W-1:0] din,
                         input logic d, input logic sr, input logic sl);
        bus.i_start   = st;
        bus.i_mode    = md;
        bus.i_data_in = din;
        bus.i_dir     = d;
        bus.i_sin_r   = sr;
        bus.i_sin_l   = sl;
    endtask

    task automatic cycle(input logic st, input logic [1:0] md, input logic [W-1:0] din,
                         input logic d, input logic sr, input logic sl);
        @(negedge clk);
        drive(st, md, din, d, sr, sl);
        model_step();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst data_out", bus.o_data_out, 0);
        chk("async_rst busy", bus.o_busy, 0);
        chk("async_rst done", bus.o_done, 0);
        chk("async_rst bit_cnt", bus.o_bit_cnt, 0);
        m_reg = '0; m_word = '0; m_dir = 1'b0; m_pos = -1; m_cnt = 0;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares every presented cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.o_busy === 1'b1) begin
                busy_cycles++;
                if (bus.o_bit_cnt < CW'(W)) cap_r[bus.o_bit_cnt] = bus.o_sout_r;
            end
            if (bus.o_done === 1'b1) done_cycles++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("data_out", bus.o_data_out, e.data);
                chk("busy", bus.o_busy, e.busy);
                chk("done", bus.o_done, e.done);
                chk("bit_cnt", bus.o_bit_cnt, e.cnt);
                chk("sout_r", bus.o_sout_r, e.data[0]);
                chk("sout_l", bus.o_sout_l, e.data[W-1]);
                if (e.ser_vld) begin
                    if (e.ser_dir) chk("burst sout_l", bus.o_sout_l, e.ser_bit);
                    else           chk("burst sout_r", bus.o_sout_r, e.ser_bit);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lbits;
        logic [W-1:0] rw;
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset while a load is active
        repeat (3) cycle(1'b0, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0);
        settle();
        chk("pre_rst data_out", bus.o_data_out, 8'hA5);
        do_reset();

        // Manual modes
        cycle(1'b0, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0);
        settle();
        chk("load A5", bus.o_data_out, 8'hA5);
        cycle(1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 1'b0);
        settle();
        chk("shr fill1", bus.o_data_out, 8'hD2);
        cycle(1'b0, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("shl fill0", bus.o_data_out, 8'hA4);
        repeat (3) cycle(1'b0, 2'b00, 8'hFF, 1'b0, 1'b1, 1'b1);
        settle();
        chk("hold", bus.o_data_out, 8'hA4);

        // Right burst
        busy_cycles = 0; done_cycles = 0; cap_r = '0;
        cycle(1'b1, 2'b00, 8'h6C, 1'b0, 1'b0, 1'b0);
        repeat (W) cycle(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("rburst done", bus.o_done, 1);
        chk("rburst bit_cnt", bus.o_bit_cnt, W);
        chk("rburst data_out", bus.o_data_out, 8'h00);
        cycle(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("rburst busy cycles", busy_cycles, W);
        chk("rburst done cycles", done_cycles, 1);
        chk("rburst sout_r seq", cap_r, 8'h6C);
        chk("rburst idle bit_cnt", bus.o_bit_cnt, W);

        // Left burst, deserialise
        lbits = 8'hB3;
        cycle(1'b1, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < W; k++) cycle(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, lbits[W-1-k]);
        settle();
        chk("lburst done", bus.o_done, 1);
        chk("lburst data_out", bus.o_data_out, 8'hB3);
        cycle(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Inputs ignored during SHIFT and DONE
        busy_cycles = 0; done_cycles = 0;
        rw = W'($urandom);
        cycle(1'b1, 2'b00, rw, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < W; k++) begin
            if (k == 3) cycle(1'b1, 2'b11, ~rw, 1'b1, 1'b0, 1'b0);
            else        cycle(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        settle();
        chk("ignore done", bus.o_done, 1);
        chk("ignore data_out", bus.o_data_out, 8'h00);
        cycle(1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0);
        settle();
        chk("ignore no 2nd burst", bus.o_busy, 0);
        chk("ignore no load in done", bus.o_data_out, 8'h00);
        chk("ignore busy cycles", busy_cycles, W);
        chk("ignore done cycles", done_cycles, 1);
        cycle(1'b1, 2'b00, 8'h5A, 1'b0, 1'b0, 1'b0);
        settle();
        chk("b2b start busy", bus.o_busy, 1);
        chk("b2b start data", bus.o_data_out, 8'h5A);
        repeat (W + 1) cycle(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset mid-burst
        cycle(1'b1, 2'b00, W'($urandom), 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0);
        settle();
        chk("midrst bit_cnt", bus.o_bit_cnt, 3);
        chk("midrst busy", bus.o_busy, 1);
        do_reset();
        busy_cycles = 0; done_cycles = 0;
        cycle(1'b1, 2'b00, 8'hC3, 1'b1, 1'b0, 1'b0);
        repeat (W + 1) cycle(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1);
        settle();
        chk("postrst busy cycles", busy_cycles, W);
        chk("postrst done cycles", done_cycles, 1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 7) == 0), 2'($urandom), W'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
        end
        repeat (W + 3) cycle(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: the next generation of the team's 4-bit parallel-in/parallel-out register. It adds a WIDTH parameter, four manual modes (hold, shift right, shift left, parallel load), serial inputs and outputs at both ends, and a burst serialiser. The serialiser loads a word and shifts it out over exactly WIDTH cycles, with busy/done status. It sits between parallel datapaths and serial links, as a serialiser, a deserialiser or a plain pipeline register.

## Interface
- WIDTH, 8, register width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of bit_cnt; derived, never overridden.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (one clock, async active-low reset, fixed).
- mode  input  2  manual operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- data_in  input  WIDTH  parallel load word.
- sin_r  input  1  serial fill bit entering the MSB on a right shift.
- sin_l  input  1  serial fill bit entering the LSB on a left shift.
- start  input  1  burst request; sampled only in IDLE.
- dir  input  1  burst direction, captured with start: 0 right (LSB first), 1 left (MSB first).
- data_out  output  WIDTH  register contents.
- sout_r  output  1  combinational data_out[0].
- sout_l  output  1  combinational data_out[WIDTH-1].
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse, high while in DONE.
- bit_cnt  output  CNT_W  number of burst shifts completed.

## Operation
- Reset low, at any time, asynchronously clears the following: data_out=0, state=IDLE, busy=0, done=0, bit_cnt=0, captured dir=0.
- State machine has three states: IDLE, SHIFT and DONE.
- IDLE with start=1:
  - load data_in into the register, capture dir, set bit_cnt=0, go to SHIFT.
  - start has priority over mode.
- IDLE with start=0: mode applies.
  - 00: hold.
  - 01: data_out <= {sin_r, data_out[WIDTH-1:1]}.
  - 10: data_out <= {data_out[WIDTH-2:0], sin_l}.
  - 11: data_out <= data_in.
  - bit_cnt holds its last value.
- SHIFT: each cycle shift one bit in the captured direction, using the same fill rule as the manual shift, then increment bit_cnt.
  - When bit_cnt==WIDTH-1 on the shifting edge, this is the WIDTH-th shift: bit_cnt becomes WIDTH and the state goes to DONE.
- DONE: register holds, done=1, bit_cnt holds at WIDTH, next state IDLE.
- mode and start are ignored in SHIFT and DONE. A start in those states is dropped, not queued.
- Burst serial output:
  - Right burst: sout_r presents data_in[k] while bit_cnt==k and busy=1, for k = 0..WIDTH-1.
  - Left burst: sout_l presents data_in[WIDTH-1-k].
- Deserialise: with a burst, or with mode 01/10 held, the fill inputs are captured. After WIDTH shifts, data_out holds the received word.

## Timing
- Parallel load latency is 1 cycle; data_out updates on the edge where mode=11 or start is sampled.
- Burst length, start edge to DONE entry, is WIDTH+1 edges:
  - 1 load edge, then WIDTH shift edges.
  - busy is high for exactly WIDTH cycles.
  - done is high for exactly 1 cycle, immediately after busy falls.
- The earliest accepted back-to-back start is in the cycle after DONE (the first IDLE cycle). Minimum burst period is WIDTH+2 cycles.
- sout_r and sout_l have no extra register; they change with data_out.
- Reset deassertion: first active edge behaves as IDLE.

## Test plan
- Reset: drive mode=11, data_in=8'hA5 for 3 cycles, then pull reset low between edges -> data_out=8'h00, busy=0, done=0, bit_cnt=0 immediately, with no clock edge.
- Manual modes, WIDTH=8:
  - load 8'hA5, then mode=01 with sin_r=1 -> 8'hD2.
  - then mode=10 with sin_l=0 -> 8'hA4.
  - then mode=00 for 3 cycles -> 8'hA4 held.
- Right burst: data_in=8'h6C, dir=0, start for 1 cycle, sin_r=0 -> sout_r sequence over 8 busy cycles is 0,0,1,1,0,1,1,0; busy high 8 cycles; done pulses 1 cycle; bit_cnt=8; data_out=8'h00.
- Left burst, deserialise: data_in=8'h00, dir=1, sin_l fed 1,0,1,1,0,0,1,1 on successive shift edges -> data_out=8'hB3 in DONE.
- Ignored inputs: start and mode=11 pulsed mid-burst -> burst completes unchanged, no second burst. A start in the first IDLE cycle after DONE is accepted.
- Reset mid-burst: reset low at bit_cnt=3 -> IDLE, busy=0, no done pulse. A new start after release runs a full 8-cycle burst.
